// File: rtl/ls11_vector_sequencer.sv
// ls11_vector_sequencer
// ---------------------------------------------------------------------------
// Clocked stimulus-and-check stage for an SN74LS11 triple 3-input AND block.
// It walks idx 0..7, drives all three gates from idx, and holds each vector
// for HOLD_CYCLES cycles. On the last hold cycle it samples 1Y/2Y/3Y and
// compares them with the AND of the registered drives. It reports
// busy/done/pass and a saturating mismatch count.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 one-cycle run request, honoured in IDLE only
//   out_{1,2,3}{A,B,C}    registered gate drives
//   in_{1,2,3}Y           gate outputs returned by the AND block
//   busy                  high while vectors are being driven
//   done                  one-cycle completion pulse
//   pass                  last completed run had no mismatches
//   err_cnt               mismatches in the last/current run (saturating)
//   state_dbg             FSM state (0 IDLE, 1 DRIVE, 2 DONE)
//   fail_idx, fail_gate   first mismatch idx / gate (1..3); present only
//                         when LS11_SEQ_FIRST_FAIL_EN is defined
//
// Handshake: start is a level sampled on every rising edge while in IDLE;
// there is no ready/acknowledge, and busy is the only flow indicator.
// A start seen in DRIVE or DONE is dropped, not queued.
// ---------------------------------------------------------------------------
module ls11_vector_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             out_1A,
    output logic             out_1B,
    output logic             out_1C,
    output logic             out_2A,
    output logic             out_2B,
    output logic             out_2C,
    output logic             out_3A,
    output logic             out_3B,
    output logic             out_3C,
    input  logic             in_1Y,
    input  logic             in_2Y,
    input  logic             in_3Y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
`ifdef LS11_SEQ_FIRST_FAIL_EN
    output logic [2:0]       fail_idx,
    output logic [1:0]       fail_gate,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [7:0] hold;
    logic [8:0] drv;       // {g1 ABC, g2 ABC, g3 ABC}
    logic [8:0] drv_nxt;   // drives for idx+1
    logic [2:0] idx_inc;
    logic       cmp_now;
    logic       last_vec;
    logic       mis1, mis2, mis3;
    logic [ERR_W+1:0] err_sum;
    logic [ERR_W-1:0] err_sat;

    assign state_dbg = state;

    assign {out_1A, out_1B, out_1C, out_2A, out_2B, out_2C,
            out_3A, out_3B, out_3C} = drv;

    // Vector mapping: gate1 = idx, gate2 = ~idx, gate3 = idx rotated left.
    function automatic logic [8:0] map_vec(input logic [2:0] v);
        return {v, ~v, v[1:0], v[2]};
    endfunction

    assign idx_inc  = idx + 3'd1;
    assign drv_nxt  = map_vec(idx_inc);
    assign cmp_now  = (state == S_DRIVE) && (hold == HOLD_LAST);
    assign last_vec = (idx == 3'd7);

    // Compare against the registered drives, which are what the gates see.
    assign mis1 = in_1Y != (&drv[8:6]);
    assign mis2 = in_2Y != (&drv[5:3]);
    assign mis3 = in_3Y != (&drv[2:0]);

    assign err_sum = {2'b00, err_cnt} + (ERR_W+2)'(mis1)
                   + (ERR_W+2)'(mis2) + (ERR_W+2)'(mis3);
    assign err_sat = (err_sum > {2'b00, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DRIVE;
            S_DRIVE: if (cmp_now && last_vec) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= 3'd0;
            hold    <= 8'd0;
            drv     <= 9'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    drv <= 9'd0;
                    if (start) begin
                        idx     <= 3'd0;
                        hold    <= 8'd0;
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        busy    <= 1'b1;
                        drv     <= map_vec(3'd0);
                    end
                end
                S_DRIVE: begin
                    hold <= hold + 8'd1;
                    if (cmp_now) begin
                        err_cnt <= err_sat;
                        hold    <= 8'd0;
                        if (last_vec) begin
                            busy <= 1'b0;
                            drv  <= 9'd0;
                        end else begin
                            idx <= idx_inc;
                            drv <= drv_nxt;
                        end
                    end
                end
                S_DONE: begin
                    // err_cnt is final here; done and pass appear together.
                    done <= 1'b1;
                    pass <= (err_cnt == '0);
                    drv  <= 9'd0;
                end
                default: drv <= 9'd0;
            endcase
        end
    end

`ifdef LS11_SEQ_FIRST_FAIL_EN
    logic fail_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            fail_seen <= 1'b0;
            fail_idx  <= 3'd0;
            fail_gate <= 2'd0;
        end else if (state == S_IDLE && start) begin
            fail_seen <= 1'b0;
            fail_idx  <= 3'd0;
            fail_gate <= 2'd0;
        end else if (cmp_now && !fail_seen && (mis1 || mis2 || mis3)) begin
            fail_seen <= 1'b1;
            fail_idx  <= idx;
            fail_gate <= mis1 ? 2'd1 : (mis2 ? 2'd2 : 2'd3);
        end
    end
`endif

endmodule
